// File: rtl/cke_scheduler.sv
// Event-driven clock-enable scheduler: each clk_sys cycle advances emulated time to the next TX/RX edge.
// Optional event counters are built when CKE_EVENT_CNT_EN is defined; otherwise cnt_* read 0.
module cke_scheduler #(
  parameter int                   TIME_WIDTH = 32,
  parameter int                   PER_WIDTH  = 16,
  parameter logic [PER_WIDTH-1:0] TX_PERIOD  = 16'd1000
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  run,
  input  logic [TIME_WIDTH-1:0] stop_time,
  input  logic [PER_WIDTH-1:0]  rx_period,
  output logic                  cke_tx,
  output logic                  cke_rx_p,
  output logic                  cke_rx_n,
  output logic [TIME_WIDTH-1:0] dt,
  output logic [TIME_WIDTH-1:0] time_now,
  output logic                  done,
  output logic [31:0]           cnt_tx,
  output logic [31:0]           cnt_rx_p,
  output logic [31:0]           cnt_rx_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PER_WIDTH-1:0] NO_EDGE    = {PER_WIDTH{1'b1}};
  localparam logic [PER_WIDTH-1:0] MIN_RX_PER = {{(PER_WIDTH-2){1'b0}}, 2'd2};

  state_t                state_q;
  logic [PER_WIDTH-1:0]  t_tx_q, t_rxp_q, t_rxn_q;
  logic [PER_WIDTH-1:0]  t_tx_d, t_rxp_d, t_rxn_d;
  logic [TIME_WIDTH-1:0] time_now_q, dt_q;
  logic                  cke_tx_q, cke_rx_p_q, cke_rx_n_q, done_q;

  logic                  rxn_pend_s;
  logic [PER_WIDTH-1:0]  m_s;
  logic [PER_WIDTH-1:0]  p_s;
  logic [TIME_WIDTH:0]   sum_s;
  logic                  over_s;
  logic                  fire_tx_s, fire_rxp_s, fire_rxn_s;
  logic                  step_s;

  function automatic logic [PER_WIDTH-1:0] min2(input logic [PER_WIDTH-1:0] a,
                                                input logic [PER_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Step datapath: earliest edge, stop check at TIME_WIDTH+1 bits, and reloaded countdowns.
  always_comb begin
    rxn_pend_s = (t_rxn_q != NO_EDGE);
    m_s        = min2(t_tx_q, t_rxp_q);
    if (rxn_pend_s) begin
      m_s = min2(m_s, t_rxn_q);
    end else begin
      m_s = m_s;
    end

    sum_s  = {1'b0, time_now_q} + {{(TIME_WIDTH+1-PER_WIDTH){1'b0}}, m_s};
    over_s = (sum_s > {1'b0, stop_time});
    step_s = (state_q == S_RUN) && run && !over_s;

    fire_tx_s  = (t_tx_q == m_s);
    fire_rxp_s = (t_rxp_q == m_s);
    fire_rxn_s = rxn_pend_s && (t_rxn_q == m_s);

    p_s = (rx_period < MIN_RX_PER) ? MIN_RX_PER : rx_period;

    t_tx_d  = fire_tx_s  ? TX_PERIOD : (t_tx_q - m_s);
    t_rxp_d = fire_rxp_s ? p_s       : (t_rxp_q - m_s);

    // The falling edge always lands strictly between two rising edges, so the two never fire together.
    if (fire_rxp_s) begin
      t_rxn_d = p_s >> 1;
    end else if (fire_rxn_s) begin
      t_rxn_d = NO_EDGE;
    end else if (rxn_pend_s) begin
      t_rxn_d = t_rxn_q - m_s;
    end else begin
      t_rxn_d = t_rxn_q;
    end
  end

  // Scheduler FSM with registered enables, time and done.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      t_tx_q     <= {PER_WIDTH{1'b0}};
      t_rxp_q    <= {PER_WIDTH{1'b0}};
      t_rxn_q    <= NO_EDGE;
      time_now_q <= {TIME_WIDTH{1'b0}};
      dt_q       <= {TIME_WIDTH{1'b0}};
      cke_tx_q   <= 1'b0;
      cke_rx_p_q <= 1'b0;
      cke_rx_n_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cke_tx_q   <= 1'b0;
          cke_rx_p_q <= 1'b0;
          cke_rx_n_q <= 1'b0;
          dt_q       <= {TIME_WIDTH{1'b0}};
          done_q     <= 1'b0;
          state_q    <= run ? S_RUN : S_IDLE;
        end
        S_RUN: begin
          if (step_s) begin
            cke_tx_q   <= fire_tx_s;
            cke_rx_p_q <= fire_rxp_s;
            cke_rx_n_q <= fire_rxn_s;
            dt_q       <= {{(TIME_WIDTH-PER_WIDTH){1'b0}}, m_s};
            time_now_q <= sum_s[TIME_WIDTH-1:0];
            t_tx_q     <= t_tx_d;
            t_rxp_q    <= t_rxp_d;
            t_rxn_q    <= t_rxn_d;
            done_q     <= 1'b0;
            state_q    <= S_RUN;
          end else begin
            cke_tx_q   <= 1'b0;
            cke_rx_p_q <= 1'b0;
            cke_rx_n_q <= 1'b0;
            dt_q       <= {TIME_WIDTH{1'b0}};
            done_q     <= run;
            state_q    <= run ? S_DONE : S_IDLE;
          end
        end
        S_DONE: begin
          cke_tx_q   <= 1'b0;
          cke_rx_p_q <= 1'b0;
          cke_rx_n_q <= 1'b0;
          dt_q       <= {TIME_WIDTH{1'b0}};
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end
        default: begin
          cke_tx_q   <= 1'b0;
          cke_rx_p_q <= 1'b0;
          cke_rx_n_q <= 1'b0;
          dt_q       <= {TIME_WIDTH{1'b0}};
          done_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CKE_EVENT_CNT_EN
  logic [31:0] cnt_tx_q, cnt_rx_p_q, cnt_rx_n_q;

  // Per-type event counters, wrapping modulo 2^32.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_tx_q   <= 32'd0;
      cnt_rx_p_q <= 32'd0;
      cnt_rx_n_q <= 32'd0;
    end else if (step_s) begin
      cnt_tx_q   <= cnt_tx_q   + {31'd0, fire_tx_s};
      cnt_rx_p_q <= cnt_rx_p_q + {31'd0, fire_rxp_s};
      cnt_rx_n_q <= cnt_rx_n_q + {31'd0, fire_rxn_s};
    end else begin
      cnt_tx_q   <= cnt_tx_q;
      cnt_rx_p_q <= cnt_rx_p_q;
      cnt_rx_n_q <= cnt_rx_n_q;
    end
  end

  assign cnt_tx   = cnt_tx_q;
  assign cnt_rx_p = cnt_rx_p_q;
  assign cnt_rx_n = cnt_rx_n_q;
`else
  assign cnt_tx   = 32'd0;
  assign cnt_rx_p = 32'd0;
  assign cnt_rx_n = 32'd0;
`endif

  assign cke_tx   = cke_tx_q;
  assign cke_rx_p = cke_rx_p_q;
  assign cke_rx_n = cke_rx_n_q;
  assign dt       = dt_q;
  assign time_now = time_now_q;
  assign done     = done_q;

endmodule

// File: doc/cke_scheduler.md
# cke_scheduler

Event-driven clock-enable scheduler for the emulated link. It runs on the ungated system clock and drives the gate inputs of the clock generator: `cke_tx`, `cke_rx_p` and `cke_rx_n`. Each `clk_sys` cycle is one emulation step, and the block:
- advances emulated time to the earliest pending TX or RX edge;
- asserts the enable(s) for every edge due at that time;
- reports the time advance `dt`.

The TX period is fixed. The RX period is supplied by the receiver's DCO model each RX rising edge.

## Interface
- `TIME_WIDTH`, 32: width of emulated time, `dt`, and the stop time (units: emulator time LSB).
- `PER_WIDTH`, 16: width of period values.
- `TX_PERIOD`, 16'd1000: TX clock period in time LSBs; must be ≥ 1.

Ports:
- `clk_sys`  in  1: ungated system clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `run`  in  1: level; 1 enables stepping.
- `stop_time`  in  TIME_WIDTH: last emulated time at which an event may be emitted.
- `rx_period`  in  PER_WIDTH: RX period; sampled only on cycles where an RX rising event is emitted.
- `cke_tx`  out  1: TX clock enable (registered).
- `cke_rx_p`  out  1: RX rising-edge clock enable (registered).
- `cke_rx_n`  out  1: RX falling-edge clock enable (registered).
- `dt`  out  TIME_WIDTH: time advance of the current step.
- `time_now`  out  TIME_WIDTH: emulated time of the current step's events.
- `done`  out  1: high in DONE state.
- `cnt_tx`, `cnt_rx_p`, `cnt_rx_n`  out  32 each: event counters (see Configuration).

## Operation
- Internal countdowns `t_tx`, `t_rxp`, `t_rxn` give the time until each next edge. `t_rxn` = all-ones means no falling edge is pending.
- States and transitions:
  - IDLE → RUN when `run`=1.
  - RUN → IDLE when `run`=0.
  - RUN → DONE when the next event time exceeds `stop_time`.
  - DONE stays in DONE until `reset`.
- Reset values:
  - state IDLE; `t_tx`=0, `t_rxp`=0, `t_rxn`=all-ones.
  - all outputs 0, including the counters.
- Each RUN cycle:
  - m = min(`t_tx`, `t_rxp`, `t_rxn`).
  - If `time_now`+m > `stop_time` (unsigned, computed at TIME_WIDTH+1 bits): emit nothing, go to DONE.
  - Otherwise:
    - `dt`←m, `time_now`←`time_now`+m.
    - Assert every cke whose countdown equals m. Simultaneous events are all asserted in the same cycle.
    - Subtract m from each countdown that did not fire.
- Reload rules:
  - TX fired: `t_tx`←`TX_PERIOD`.
  - RX rising fired: p = max(`rx_period`, 2); `t_rxp`←p, `t_rxn`←p>>1 (floor).
  - RX falling fired: `t_rxn`←all-ones.
- IDLE and DONE: all ckes 0, `dt`=0, and the countdowns and `time_now` hold.
- An event exactly at `stop_time` is emitted; the next step enters DONE.
- `time_now` cannot wrap: the stop check is evaluated at TIME_WIDTH+1 bits, so any event that would pass 2^TIME_WIDTH−1 exceeds `stop_time` and the block enters DONE instead.

## Timing
- All outputs are registered. ckes, `dt` and `time_now` for a decision made in cycle n appear in cycle n+1.
- Each cke is a single-cycle pulse per event.
- With `run` held high and `stop_time` not reached, at least one cke is asserted every cycle.
- `run` falling takes effect in the next cycle: no cke in the cycle after `run`=0 is sampled.
- `reset` mid-RUN: the next cycle has all outputs 0 and state IDLE. Reset has priority over `run`.
- `rx_period` must be stable in the cycle in which the RX rising decision is made. It is sampled combinationally from the port in that cycle.

## Configuration
- `CKE_EVENT_CNT_EN` defined: `cnt_tx`, `cnt_rx_p`, `cnt_rx_n` increment on each emitted event of their type. They are 32-bit, wrap modulo 2^32, and are cleared by `reset`.
- `CKE_EVENT_CNT_EN` undefined: the counter logic is not built and all three outputs are tied to 0.

## Test plan
- Reset, then `run`=1, `rx_period`=600, `TX_PERIOD`=1000, `stop_time`=large -> first step has `dt`=0 with `cke_tx`=`cke_rx_p`=1. The next steps are:
  - `cke_rx_n` at t=300;
  - `cke_rx_p` at t=600;
  - `cke_rx_n` at t=900;
  - `cke_tx` at t=1000;
  - `cke_rx_p` at t=1200.
- `rx_period`=500 with `TX_PERIOD`=1000 -> at t=1000, `cke_tx` and `cke_rx_p` are asserted in the same cycle with `dt`=250.
- `rx_period`=1 -> clamped to 2: RX rising every 2 LSBs, falling 1 LSB after each rising edge.
- `stop_time`=1000 -> the t=1000 event is emitted, then `done`=1 with no further ckes. `done` stays set until `reset`.
- Toggle `run` low for 5 cycles mid-run -> no ckes in those cycles, and the time sequence resumes unchanged afterwards. Asserting `reset` mid-run -> all outputs are 0 in the next cycle.
- With `CKE_EVENT_CNT_EN` defined, run to t=3000 (`rx_period`=600) -> `cnt_tx`=4, `cnt_rx_p`=6, `cnt_rx_n`=5. With the macro undefined, all three counters read 0.
